// File: rtl/parity_scan_arbiter.sv
// Round-robin arbiter for two requesters. It serialises the granted word LSB-first
// and reports whether that word held an even number of ones, tagged with the requester.
module parity_scan_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             gclk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             grant0,
  output logic             grant1,
  output logic             busy,
  output logic             serial_valid,
  output logic             serial_bit,
  output logic             done,
  output logic             done_id,
  output logic             is_even
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             parity_q, parity_d;
  logic             last_q, last_d;
  logic             grant0_q, grant0_d;
  logic             grant1_q, grant1_d;
  logic             done_id_q, done_id_d;
  logic             is_even_q, is_even_d;

  logic             arb_vld;
  logic             arb_sel;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    arb_vld = req0 | req1;
    arb_sel = (req0 & req1) ? ~last_q : req1;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    parity_d  = parity_q;
    last_d    = last_q;
    grant0_d  = 1'b0;
    grant1_d  = 1'b0;
    done_id_d = done_id_q;
    is_even_d = is_even_q;
    case (state_q)
      IDLE, REPORT: begin
        if (arb_vld) begin
          shift_d  = arb_sel ? data1 : data0;
          cnt_d    = '0;
          parity_d = 1'b0;
          last_d   = arb_sel;
          grant0_d = ~arb_sel;
          grant1_d = arb_sel;
          state_d  = SCAN;
        end else begin
          state_d  = IDLE;
        end
      end
      SCAN: begin
        parity_d = parity_q ^ shift_q[0];
        shift_d  = shift_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // last_q still identifies the requester whose word is in flight
        if (cnt_d == CNT_LAST) begin
          state_d   = REPORT;
          is_even_d = ~parity_d;
          done_id_d = last_q;
        end
      end
      default: begin
        state_d   = IDLE;
        shift_d   = '0;
        cnt_d     = '0;
        parity_d  = 1'b0;
        last_d    = 1'b1;
        done_id_d = 1'b0;
        is_even_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      parity_q  <= 1'b0;
      last_q    <= 1'b1;
      grant0_q  <= 1'b0;
      grant1_q  <= 1'b0;
      done_id_q <= 1'b0;
      is_even_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      parity_q  <= parity_d;
      last_q    <= last_d;
      grant0_q  <= grant0_d;
      grant1_q  <= grant1_d;
      done_id_q <= done_id_d;
      is_even_q <= is_even_d;
    end
  end

  // Status outputs are decoded purely from registered state.
  always_comb begin
    busy         = 1'b0;
    serial_valid = 1'b0;
    serial_bit   = 1'b0;
    done         = 1'b0;
    case (state_q)
      SCAN: begin
        busy         = 1'b1;
        serial_valid = 1'b1;
        serial_bit   = shift_q[0];
      end
      REPORT:  done = 1'b1;
      default: ;
    endcase
  end

  assign grant0  = grant0_q;
  assign grant1  = grant1_q;
  assign done_id = done_id_q;
  assign is_even = is_even_q;

endmodule

// File: tb/tb_parity_scan_arbiter.sv
// Scoreboard bench: expected words are queued as requests are driven; a negedge
// monitor collects serial bits, grants and done results for the tests to compare.
module tb_parity_scan_arbiter;

  logic gclk = 1'b0;
  logic reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic grant0, grant1, busy, serial_valid, serial_bit, done, done_id, is_even;

  logic req0_w1 = 1'b0;
  logic [0:0] data0_w1 = '0, data1_w1 = '0;
  logic grant0_w1, grant1_w1, busy_w1, serial_valid_w1, serial_bit_w1, done_w1, done_id_w1, is_even_w1;

  parity_scan_arbiter #(.WIDTH(8)) dut (
    .gclk(gclk), .reset(reset), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .grant0(grant0), .grant1(grant1), .busy(busy), .serial_valid(serial_valid),
    .serial_bit(serial_bit), .done(done), .done_id(done_id), .is_even(is_even));

  parity_scan_arbiter #(.WIDTH(1)) dut_w1 (
    .gclk(gclk), .reset(reset), .req0(req0_w1), .data0(data0_w1), .req1(1'b0), .data1(data1_w1),
    .grant0(grant0_w1), .grant1(grant1_w1), .busy(busy_w1), .serial_valid(serial_valid_w1),
    .serial_bit(serial_bit_w1), .done(done_w1), .done_id(done_id_w1), .is_even(is_even_w1));

  always #5 gclk = ~gclk;

  typedef struct {
    logic       id;
    logic       even;
    logic [7:0] word;
    int         nbits;
    int         cyc;
  } res_t;

  typedef struct {
    logic id;
    int   cyc;
  } gnt_t;

  res_t exp_q[$];
  res_t res_q[$];
  gnt_t gnt_q[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   chk_cnt = 0;

  always @(posedge gclk) cyc <= cyc + 1;

  // Monitor: assemble the serial word and log grants and done results.
  logic [7:0] sb_word = '0;
  int         sb_cnt = 0;
  always @(negedge gclk) begin
    if (reset) begin
      sb_word = '0;
      sb_cnt  = 0;
    end else begin
      if (serial_valid) begin
        if (sb_cnt < 8) sb_word[sb_cnt] = serial_bit;
        sb_cnt++;
      end
      if (grant0) gnt_q.push_back('{1'b0, cyc});
      if (grant1) gnt_q.push_back('{1'b1, cyc});
      if (done) begin
        res_q.push_back('{done_id, is_even, sb_word, sb_cnt, cyc});
        sb_word = '0;
        sb_cnt  = 0;
        chk_cnt++;
        if (serial_valid) $display("FAIL done_overlap: serial_valid=%0b required 0 at done", serial_valid);
        else pass_cnt++;
      end
    end
  end

  task automatic send(input logic id, input logic [7:0] d);
    bit seen = 0;
    exp_q.push_back('{id, ~^d, d, 8, 0});
    @(negedge gclk);
    if (id) begin req1 = 1'b1; data1 = d; end
    else begin req0 = 1'b1; data0 = d; end
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge gclk);
      if (id ? grant1 : grant0) seen = 1;
    end
    if (!seen) begin
      chk_cnt++;
      $display("FAIL send_grant: no grant%0b within 30 cycles, required a grant", id);
    end
    if (id) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 120 && res_q.size() < n; i++) @(negedge gclk);
    @(negedge gclk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge gclk);
    chk_cnt++;
    if ({grant0, grant1, busy, serial_valid, serial_bit, done, done_id, is_even} !== 8'b0000_0001)
      $display("FAIL reset_outputs: got %b required 00000001",
               {grant0, grant1, busy, serial_valid, serial_bit, done, done_id, is_even});
    else pass_cnt++;
    chk_cnt++;
    if ({done_w1, is_even_w1, serial_valid_w1} !== 3'b010)
      $display("FAIL reset_w1: got %b required 010", {done_w1, is_even_w1, serial_valid_w1});
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    res_t e, r;
    gnt_t g;
    gnt_q.delete(); res_q.delete();
    send(1'b0, 8'hB4);
    wait_results(1);
    chk_cnt++;
    if (gnt_q.size() != 1 || res_q.size() != 1) begin
      $display("FAIL single_count: grants=%0d results=%0d required 1/1", gnt_q.size(), res_q.size());
      exp_q.delete();
      return;
    end
    pass_cnt++;
    g = gnt_q.pop_front(); r = res_q.pop_front(); e = exp_q.pop_front();
    chk_cnt++;
    if (g.id !== 1'b0) $display("FAIL single_grant_id: got %0b required 0", g.id); else pass_cnt++;
    chk_cnt++;
    if (r.id !== e.id || r.even !== e.even || r.word !== e.word || r.nbits != e.nbits)
      $display("FAIL single_result: got id=%0b even=%0b word=%h bits=%0d required id=%0b even=%0b word=%h bits=%0d",
               r.id, r.even, r.word, r.nbits, e.id, e.even, e.word, e.nbits);
    else pass_cnt++;
    chk_cnt++;
    if (r.cyc - g.cyc != 8) $display("FAIL single_latency: got %0d required 8", r.cyc - g.cyc);
    else pass_cnt++;
    repeat (3) @(negedge gclk);
    chk_cnt++;
    if (is_even !== 1'b1 || busy !== 1'b0)
      $display("FAIL single_hold: is_even=%0b busy=%0b required 1/0", is_even, busy);
    else pass_cnt++;
  endtask

  task automatic test_req1();
    res_t e, r;
    gnt_t g;
    gnt_q.delete(); res_q.delete();
    send(1'b1, 8'h07);
    wait_results(1);
    send(1'b1, 8'h00);
    wait_results(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (res_q.size() == 0 || gnt_q.size() == 0) begin
        $display("FAIL req1_missing: result for word %h missing, required one", e.word);
        continue;
      end
      r = res_q.pop_front(); g = gnt_q.pop_front();
      if (r.id !== e.id || r.even !== e.even || r.word !== e.word || r.nbits != e.nbits || r.cyc - g.cyc != 8)
        $display("FAIL req1_result: got id=%0b even=%0b word=%h lat=%0d required id=%0b even=%0b word=%h lat=8",
                 r.id, r.even, r.word, r.cyc - g.cyc, e.id, e.even, e.word);
      else pass_cnt++;
    end
  endtask

  task automatic test_alternate();
    res_t e, r;
    int ng = 0;
    logic [3:0] ids = 4'b0000;
    int gc[4], dc[4];
    gnt_q.delete(); res_q.delete();
    exp_q.push_back('{1'b0, 1'b1, 8'hA5, 8, 0});
    exp_q.push_back('{1'b1, 1'b1, 8'h3C, 8, 0});
    exp_q.push_back('{1'b0, 1'b1, 8'hA5, 8, 0});
    exp_q.push_back('{1'b1, 1'b1, 8'h3C, 8, 0});
    @(negedge gclk);
    data0 = 8'hA5; data1 = 8'h3C; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 80 && ng < 4; i++) begin
      @(negedge gclk);
      if (grant0 | grant1) ng++;
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_results(4);
    chk_cnt++;
    if (gnt_q.size() != 4 || res_q.size() != 4) begin
      $display("FAIL alt_count: grants=%0d results=%0d required 4/4", gnt_q.size(), res_q.size());
      exp_q.delete();
      return;
    end
    pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      gnt_t g;
      g = gnt_q.pop_front(); ids[i] = g.id; gc[i] = g.cyc;
      e = exp_q.pop_front(); r = res_q.pop_front(); dc[i] = r.cyc;
      chk_cnt++;
      if (r.id !== e.id || r.even !== e.even || r.word !== e.word || r.nbits != e.nbits)
        $display("FAIL alt_result%0d: got id=%0b word=%h required id=%0b word=%h", i, r.id, r.word, e.id, e.word);
      else pass_cnt++;
    end
    chk_cnt++;
    if (ids !== 4'b1010) $display("FAIL alt_order: got %b (bit0 first) required 1010", ids); else pass_cnt++;
    chk_cnt++;
    if (gc[1] - gc[0] != 9 || gc[2] - gc[1] != 9 || gc[3] - gc[2] != 9 || dc[3] - dc[0] != 27)
      $display("FAIL alt_spacing: grant gaps %0d,%0d,%0d done span %0d required 9,9,9 and 27",
               gc[1] - gc[0], gc[2] - gc[1], gc[3] - gc[2], dc[3] - dc[0]);
    else pass_cnt++;
  endtask

  task automatic test_tie();
    res_t e, r;
    gnt_t g0, g1;
    int ng = 0;
    send(1'b0, 8'h01);
    wait_results(1);
    gnt_q.delete(); res_q.delete(); exp_q.delete();
    exp_q.push_back('{1'b1, 1'b0, 8'h5B, 8, 0});
    exp_q.push_back('{1'b1, 1'b0, 8'h5B, 8, 0});
    @(negedge gclk);
    data0 = 8'hFF; data1 = 8'h5B; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 60 && ng < 2; i++) begin
      @(negedge gclk);
      if (grant0 | grant1) begin ng++; req0 = 1'b0; end
    end
    req1 = 1'b0;
    wait_results(2);
    chk_cnt++;
    if (gnt_q.size() != 2 || res_q.size() != 2) begin
      $display("FAIL tie_count: grants=%0d results=%0d required 2/2", gnt_q.size(), res_q.size());
      exp_q.delete();
      return;
    end
    pass_cnt++;
    g0 = gnt_q.pop_front(); g1 = gnt_q.pop_front();
    chk_cnt++;
    if (g0.id !== 1'b1 || g1.id !== 1'b1 || g1.cyc - g0.cyc != 9)
      $display("FAIL tie_grants: got %0b,%0b gap %0d required 1,1 gap 9", g0.id, g1.id, g1.cyc - g0.cyc);
    else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); r = res_q.pop_front();
      chk_cnt++;
      if (r.id !== e.id || r.even !== e.even || r.word !== e.word)
        $display("FAIL tie_result: got id=%0b even=%0b word=%h required id=%0b even=%0b word=%h",
                 r.id, r.even, r.word, e.id, e.even, e.word);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midscan();
    res_t e, r;
    bit seen = 0;
    gnt_q.delete(); res_q.delete(); exp_q.delete();
    @(negedge gclk);
    req0 = 1'b1; data0 = 8'hFF;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge gclk);
      if (grant0) seen = 1;
    end
    req0 = 1'b0;
    repeat (2) @(negedge gclk);
    chk_cnt++;
    if (serial_valid !== 1'b1 || is_even !== 1'b0)
      $display("FAIL midscan_pre: serial_valid=%0b is_even=%0b required 1/0", serial_valid, is_even);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    chk_cnt++;
    if ({grant0, grant1, busy, serial_valid, serial_bit, done, done_id, is_even} !== 8'b0000_0001)
      $display("FAIL midscan_reset: got %b required 00000001",
               {grant0, grant1, busy, serial_valid, serial_bit, done, done_id, is_even});
    else pass_cnt++;
    @(negedge gclk);
    reset = 1'b0;
    repeat (12) @(negedge gclk);
    chk_cnt++;
    if (res_q.size() != 0) $display("FAIL midscan_nodone: got %0d results required 0", res_q.size());
    else pass_cnt++;
    send(1'b1, 8'h81);
    wait_results(1);
    e = exp_q.pop_front();
    chk_cnt++;
    if (res_q.size() != 1) $display("FAIL midscan_after: got %0d results required 1", res_q.size());
    else begin
      r = res_q.pop_front();
      if (r.id !== e.id || r.even !== e.even || r.word !== e.word || r.nbits != 8)
        $display("FAIL midscan_after: got id=%0b even=%0b word=%h bits=%0d required id=1 even=1 word=81 bits=8",
                 r.id, r.even, r.word, r.nbits);
      else pass_cnt++;
    end
  endtask

  task automatic test_width1();
    @(negedge gclk);
    req0_w1 = 1'b1; data0_w1 = 1'b1;
    @(negedge gclk);
    req0_w1 = 1'b0;
    chk_cnt++;
    if ({grant0_w1, busy_w1, serial_valid_w1, serial_bit_w1, done_w1} !== 5'b11110)
      $display("FAIL w1_scan: got %b required 11110", {grant0_w1, busy_w1, serial_valid_w1, serial_bit_w1, done_w1});
    else pass_cnt++;
    @(negedge gclk);
    chk_cnt++;
    if ({done_w1, is_even_w1, done_id_w1, serial_valid_w1, grant0_w1} !== 5'b10000)
      $display("FAIL w1_done: got %b required 10000", {done_w1, is_even_w1, done_id_w1, serial_valid_w1, grant0_w1});
    else pass_cnt++;
    @(negedge gclk);
    chk_cnt++;
    if ({done_w1, busy_w1, is_even_w1} !== 3'b000)
      $display("FAIL w1_idle: got %b required 000", {done_w1, busy_w1, is_even_w1});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_req1();
    test_alternate();
    test_tie();
    test_reset_midscan();
    test_width1();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
